// File: rtl/rr_grant_pkg.sv
// rr_grant_pkg: shared constants for the four-channel round-robin grant
// sequencer. Holds the channel count, the grant index width and the FSM
// state encodings.
package rr_grant_pkg;
    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;

    // FSM state encodings
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin pick over four requesters.
//   req_i    [3:0] per-channel request
//   ptr_i    [1:0] highest-priority channel for this pick
//   pick_idx [1:0] first requesting channel scanning ptr, ptr+1, ... (mod 4)
//   any_req        at least one request is set (pick_idx valid)
module rr_pick4
    import rr_grant_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [IDX_W-1:0]  pick_idx,
    output logic              any_req
);
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        pick_idx = '0;
        found    = 1'b0;
        cand     = '0;
        any_req  = |req_i;
        for (int k = 0; k < NUM_CH; k++) begin
            // 2-bit add wraps 3 -> 0 naturally
            cand = ptr_i + IDX_W'(k);
            if (!found && req_i[cand]) begin
                pick_idx = cand;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer: four-channel round-robin arbiter with registered
// grant index and valid flag. The grant is held until the owner asserts
// done or drops its request; on release the pointer moves past the owner
// and a new grant is issued in the same cycle (no bubble).
//
// Optional feature (macro RR_GRANT_SEQUENCER_HOLD_TIMEOUT_EN): a grant is
// force-released after MAX_HOLD cycles and timeout pulses for one cycle.
// Without the macro the hold counter runs but has no effect, timeout = 0.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req   [3:0]  per-channel requests
//   done         owner releases grant this cycle (ignored in IDLE)
//   grant_idx    [1:0] granted channel (decoder select, bit1 = a, bit0 = b)
//   grant_valid  grant_idx is meaningful
//   timeout      one-cycle pulse after a forced release
module rr_grant_sequencer
    import rr_grant_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid,
    output logic              timeout
);
    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    logic             owner_req;
    logic             forced;
    logic             release_c;
    logic [IDX_W-1:0] arb_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;

    assign owner_req = req[idx_q];

`ifdef RR_GRANT_SEQUENCER_HOLD_TIMEOUT_EN
    assign forced = (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
    assign forced = 1'b0;
`endif

    assign release_c = (state_q == GRANT) && (done || !owner_req || forced);

    // On release, arbitrate with the pointer already moved past the owner
    assign arb_ptr = release_c ? idx_q + IDX_W'(1) : ptr_q;

    rr_pick4 u_pick (
        .req_i    (req),
        .ptr_i    (arb_ptr),
        .pick_idx (pick_idx),
        .any_req  (any_req)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        // timeout only when the forced limit is the sole release reason
        to_d    = release_c && forced && !done && owner_req;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (release_c) begin
                    ptr_d = arb_ptr;
                    if (any_req) begin
                        idx_d = pick_idx;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign grant_idx   = idx_q;
    assign grant_valid = (state_q == GRANT);
    assign timeout     = to_q;
endmodule

// File: tb/tb_rr_grant_sequencer.sv
module tb_rr_grant_sequencer;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int compared = 0;
    int mismatched = 0;

    // reference model state: who owns the grant and for how many cycles
    int m_valid, m_owner, m_ptr, m_held, m_to;

    rr_grant_sequencer #(.MAX_HOLD(MH), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
    endtask

    task automatic model_step();
        int nxt;
        bit forced;
        forced = 1'b0;
        m_to = 0;
        if (m_valid == 0) begin
            if (req != 4'b0000) begin
                m_owner = pick(req, m_ptr);
                m_valid = 1;
                m_held = 1;
            end
        end else begin
`ifdef RR_GRANT_SEQUENCER_HOLD_TIMEOUT_EN
            forced = (m_held == MH);
`endif
            if (done || !req[m_owner] || forced) begin
                m_to = (forced && !done && req[m_owner]) ? 1 : 0;
                m_ptr = (m_owner + 1) % 4;
                nxt = pick(req, m_ptr);
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_held = 1;
                end else begin
                    m_valid = 0;
                end
            end else begin
                m_held++;
            end
        end
    endtask

    function automatic logic [3:0] exp_vec();
        logic [1:0] o;
        o = m_valid != 0 ? 2'(m_owner) : 2'b00;
        return {m_valid != 0, o, m_to != 0};
    endfunction

    function automatic logic [3:0] act_vec();
        return {grant_valid, grant_valid ? grant_idx : 2'b00, timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        done = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({grant_valid, grant_idx, timeout} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_state: got v/idx/to=%b want 0000", {grant_valid, grant_idx, timeout});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            compared++;
            if ({grant_valid, grant_idx, timeout} !== 4'b0000) begin
                mismatched++;
                $display("FAIL reset_idle c%0d: got %b want 0000", i, {grant_valid, grant_idx, timeout});
            end
        end
    endtask

    task automatic test_rotate();
        do_reset();
        req = 4'b1111;
        tick();
        compared++;
        if (act_vec() !== exp_vec() || grant_idx !== 2'd0 || grant_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL rotate_first: got %b want %b", act_vec(), exp_vec());
        end
        for (int i = 1; i <= 4; i++) begin
            done = 1'b1;
            tick();
            compared++;
            if (act_vec() !== exp_vec() || grant_valid !== 1'b1 || grant_idx !== 2'(i % 4)) begin
                mismatched++;
                $display("FAIL rotate_seq%0d: got %b want idx %0d model %b", i, act_vec(), i % 4, exp_vec());
            end
        end
        done = 1'b0;
    endtask

    task automatic test_req_drop();
        logic [3:0] want [5];
        logic [3:0] stim [5];
        do_reset();
        // grant 1, drop it -> ptr=2 and idle; then 0101 from ptr 2
        stim = '{4'b0010, 4'b0000, 4'b0101, 4'b0001, 4'b0000};
        want = '{4'b1010, 4'b0000, 4'b1100, 4'b1000, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            req = stim[i];
            tick();
            compared++;
            if (act_vec() !== want[i] || act_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL req_drop s%0d: got %b want %b model %b", i, act_vec(), want[i], exp_vec());
            end
        end
    endtask

    task automatic test_hold();
        int n_to;
        int exp_to;
        n_to = 0;
        exp_to = 0;
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (timeout === 1'b1) n_to++;
            if (m_to != 0) exp_to++;
            compared++;
            if (act_vec() !== exp_vec() || grant_valid !== 1'b1 || grant_idx !== 2'd1) begin
                mismatched++;
                $display("FAIL hold c%0d: got %b want %b", i, act_vec(), exp_vec());
            end
        end
`ifdef RR_GRANT_SEQUENCER_HOLD_TIMEOUT_EN
        compared++;
        if (n_to !== 14 || exp_to != 14) begin
            mismatched++;
            $display("FAIL hold_timeouts: got %0d want 14", n_to);
        end
`else
        compared++;
        if (n_to !== 0) begin
            mismatched++;
            $display("FAIL hold_timeouts: got %0d want 0", n_to);
        end
`endif
        req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1000;
        tick();
        tick();
        compared++;
        if (grant_valid !== 1'b1 || grant_idx !== 2'd3) begin
            mismatched++;
            $display("FAIL mid_pre: got v=%b idx=%0d want v=1 idx=3", grant_valid, grant_idx);
        end
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        compared++;
        if ({grant_valid, grant_idx, timeout} !== 4'b0000) begin
            mismatched++;
            $display("FAIL mid_async: got %b want 0000", {grant_valid, grant_idx, timeout});
        end
        @(posedge clk);
        #1;
        compared++;
        if ({grant_valid, grant_idx, timeout} !== 4'b0000) begin
            mismatched++;
            $display("FAIL mid_held: got %b want 0000", {grant_valid, grant_idx, timeout});
        end
        rst_n = 1'b1;
        tick();
        compared++;
        if (act_vec() !== 4'b1110 || act_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL mid_resume: got %b want 1110", act_vec());
        end
        req = 4'b1001;
        done = 1'b1;
        tick();
        done = 1'b0;
        compared++;
        // after 3 releases, ptr wraps to 0 and channel 0 wins
        if (act_vec() !== 4'b1000 || act_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL mid_wrap: got %b want 1000", act_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #2 rst_n = 1'b1;
            end
            tick();
            compared++;
            if (act_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL random c%0d: req=%b done=%b got %b want %b", i, req, done, act_vec(), exp_vec());
            end
        end
        req = 4'b0000;
        done = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotate();
        test_req_drop();
        test_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rr_grant_sequencer.md
Name: rr_grant_sequencer

Overview:
- Four-channel round-robin arbiter that produces a registered 2-bit grant index plus a valid flag.
- Sits directly upstream of the 2-to-4 decoder: grant_idx drives the decoder's two select inputs, and the decoder's one-hot output becomes the per-channel grant.
- Holds a grant until the owner signals done or drops its request. Rotates priority so no channel starves.

Parameters:
- MAX_HOLD, 16: maximum cycles one channel may hold the grant; used only when HOLD_TIMEOUT_EN is defined. Legal range 2..255.
- CNT_W, 8: width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  per-channel request, bit i = channel i.
- done  input  1  current owner releases the grant this cycle.
- grant_idx  output  2  index of the granted channel, to decoder select (bit1 = a, bit0 = b).
- grant_valid  output  1  grant_idx is meaningful.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset, asynchronous, effective immediately, including mid-grant:
  - grant_valid=0, grant_idx=2'b00, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state IDLE.
- States: IDLE, GRANT. All outputs are registered.
- Pick function: first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3, all mod 4. Index wrap 3->0 is required.
- IDLE:
  - If req!=0: next cycle grant_valid=1, grant_idx=pick, state GRANT, counter=0.
  - Else remain IDLE.
  - Latency from req rising to grant_valid is exactly 1 cycle.
- GRANT:
  - grant_idx is stable.
  - Counter increments each cycle, saturating at MAX_HOLD.
  - Release condition: done=1, OR req[grant_idx]=0, OR (with macro) counter==MAX_HOLD-1.
  - On release: ptr <= grant_idx+1 mod 4, and re-arbitrate in the same cycle using the updated pointer.
    - If any req is set (the releasing channel now has lowest priority), the new grant appears next cycle with no bubble, and grant_valid stays 1.
    - Else grant_valid=0 next cycle and state goes to IDLE.
- done while IDLE is ignored.
- done asserted together with the owner dropping req is a single release, not double-counted.
- Same channel re-granted back-to-back is allowed only when it is the sole requester. The counter restarts at 0 on every new grant.
- Requests from non-owners during GRANT are not latched. Arbitration uses req only at the release cycle.
- timeout is 0 in every cycle except as described under Optional Feature.

Optional Feature:
- Macro: RR_GRANT_SEQUENCER_HOLD_TIMEOUT_EN.
- Defined:
  - Counter reaching MAX_HOLD-1 without another release condition forces release.
  - timeout=1 for exactly the cycle after the forced release; the next grant, if any, is valid in that same cycle.
  - done and timeout coinciding: treat as a done release, timeout=0.
- Undefined:
  - No forced release; a grant is held indefinitely.
  - timeout is tied to 0.
  - The counter still exists but has no effect.

Decomposition:
- Package rr_grant_pkg holds:
  - state encodings IDLE=1'b0, GRANT=1'b1;
  - NUM_CH=4;
  - IDX_W=2.
- One natural sub-module: rr_pick4, purely combinational. Inputs are req[3:0] and ptr[1:0]; outputs are pick_idx[1:0] and any_req.
- The top module holds the FSM, pointer, counter and output registers.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> grant_valid=0, grant_idx=00, timeout=0 throughout.
- req=4'b1111 held, pulse done each grant -> grant_idx sequence 0,1,2,3,0; grant_valid never drops; each grant is 1 cycle after the previous done.
- Owner req drop: ptr=2, req=4'b0101 -> grant 2. Then req=4'b0001 -> release, grant 0 next cycle. Then req=4'b0000 -> grant_valid=0 and IDLE the following cycle.
- Timeout (macro on, MAX_HOLD=4): req=4'b0010 held, done=0 -> grant 1 for 4 cycles. Then timeout=1 for one cycle and grant 1 re-issued (sole requester), with the counter restarted.
- Same stimulus with the macro off -> grant 1 held for 50+ cycles, timeout stays 0.
- Reset mid-grant: rst_n low for 1 cycle while grant_idx=3 -> outputs clear immediately (asynchronous). After release with req=4'b1000, grant 3 resumes with ptr=0 ordering.
